// File: rtl/tx_uart_arbiter.sv
// tx_uart_arbiter
//   Round-robin front end that shares one tx_uart transmitter among N_REQ
//   byte producers. A byte is accepted over a valid/ready handshake and
//   framed as {stop=1, data[7:0], start=0}. The block then strobes the
//   transmitter once and holds the frame until the transmitter reports idle
//   again.
//
// Ports
//   clk            system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_req_valid    per-requester byte valid
//   i_req_data     requester k byte at [8k+7:8k]
//   o_req_ready    one-hot accept (combinational, IDLE only)
//   i_bit_tx       transmitter bit index, 4'hF = idle, 0..9 = bit in flight
//   o_start_tx     one-cycle start strobe (decoded from the START state)
//   o_tx_frame     10-bit line frame presented to the transmitter
//   o_grant_id     index of the requester owning the current frame
//   o_busy         high whenever the controller is not IDLE
//   o_err_timeout  one-cycle pulse when the transmitter ignores a start
module tx_uart_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ID_BITS        = 2,
  parameter int GAP_CLOCKS     = 0,
  parameter int TIMEOUT_CLOCKS = 16
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [8*N_REQ-1:0]   i_req_data,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic [3:0]           i_bit_tx,
  output logic                 o_start_tx,
  output logic [9:0]           o_tx_frame,
  output logic [ID_BITS-1:0]   o_grant_id,
  output logic                 o_busy,
  output logic                 o_err_timeout
);

  localparam int TO_W  = $clog2(TIMEOUT_CLOCKS) + 1;
  localparam int GAP_W = $clog2(GAP_CLOCKS + 1) + 1;
  localparam int CW    = ID_BITS + 1;
  localparam logic [TO_W-1:0]    TO_LOAD  = TO_W'(TIMEOUT_CLOCKS - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD = (GAP_CLOCKS > 0) ? GAP_W'(GAP_CLOCKS - 1) : GAP_W'(0);
  localparam logic [3:0]         BIT_IDLE = 4'hF;
  localparam logic [ID_BITS-1:0] LAST_ID  = ID_BITS'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [ID_BITS-1:0] rr_ptr_r;
  logic [9:0]         frame_r;
  logic [ID_BITS-1:0] grant_r;
  logic [TO_W-1:0]    to_cnt_r, to_cnt_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic               found_s;
  logic [ID_BITS-1:0] pick_s;
  logic [CW-1:0]      cand_s;
  logic               accept_s;
  logic               err_s;
  logic [7:0]         pick_byte_s;

  // Find the first valid requester scanning upward from rr_ptr with wrap.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = {1'b0, rr_ptr_r} + CW'(i);
      if (cand_s >= CW'(N_REQ)) begin
        cand_s = cand_s - CW'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && i_req_valid[cand_s[ID_BITS-1:0]]) begin
        found_s = 1'b1;
        pick_s  = cand_s[ID_BITS-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Reset is folded in so no accept is advertised while the block is held in reset.
  assign accept_s    = (state_r == S_IDLE) && found_s && i_reset_n;
  assign pick_byte_s = i_req_data[{pick_s, 3'b000} +: 8];

  // One-hot ready for the selected requester, IDLE only.
  always_comb begin
    o_req_ready = '0;
    if (accept_s) begin
      o_req_ready[pick_s] = 1'b1;
    end else begin
      o_req_ready = '0;
    end
  end

  // Next-state logic; counters only decrement when non-zero so they cannot wrap.
  always_comb begin
    state_s   = state_r;
    to_cnt_s  = to_cnt_r;
    gap_cnt_s = gap_cnt_r;
    err_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        to_cnt_s = TO_LOAD;
        state_s  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_bit_tx != BIT_IDLE) begin
          state_s = S_WAIT_DONE;
        end else if (to_cnt_r == '0) begin
          err_s   = 1'b1;
          state_s = S_IDLE;
        end else begin
          to_cnt_s = to_cnt_r - TO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (i_bit_tx != BIT_IDLE) begin
          state_s = S_WAIT_DONE;
        end else if (GAP_CLOCKS == 0) begin
          state_s = S_IDLE;
        end else begin
          gap_cnt_s = GAP_LOAD;
          state_s   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_r == '0) begin
          state_s = S_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r - GAP_W'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, counters, and the frame/grant captured on accept.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= S_IDLE;
      rr_ptr_r  <= '0;
      frame_r   <= 10'h3FF;
      grant_r   <= '0;
      to_cnt_r  <= '0;
      gap_cnt_r <= '0;
    end else begin
      state_r   <= state_s;
      to_cnt_r  <= to_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      if (accept_s) begin
        frame_r  <= {1'b1, pick_byte_s, 1'b0};
        grant_r  <= pick_s;
        rr_ptr_r <= (pick_s == LAST_ID) ? '0 : pick_s + ID_BITS'(1);
      end
    end
  end

  assign o_start_tx    = (state_r == S_START);
  assign o_busy        = (state_r != S_IDLE);
  // The timeout pulse coincides with the last WAIT_BUSY cycle, TIMEOUT_CLOCKS after START.
  assign o_err_timeout = err_s;
  assign o_tx_frame    = frame_r;
  assign o_grant_id    = grant_r;

endmodule

// File: tb/tb_tx_uart_arbiter.sv
// Directed bench for tx_uart_arbiter. Instance A uses back-to-back frames,
// instance B inserts 5 gap clocks. Each instance is driven by a small
// tx_uart model with 4 clocks per baud.
module tb_tx_uart_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  valid_a = 4'b0000;
  logic [3:0]  valid_b = 4'b0000;
  logic [31:0] data_a = 32'h0;
  logic [31:0] data_b = 32'h0000005A;
  logic        tie_a = 1'b0;

  logic [3:0]  ready_a, ready_b;
  logic [3:0]  bit_a, bit_b;
  logic        start_a, start_b, busy_a, busy_b, err_a, err_b;
  logic [9:0]  tx_frame_a, tx_frame_b;
  logic [1:0]  grant_a, grant_b;
  int          baud_a, baud_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tx_uart_arbiter #(.N_REQ(4), .ID_BITS(2), .GAP_CLOCKS(0), .TIMEOUT_CLOCKS(16)) dut_a (
    .clk(clk), .i_reset_n(rst_n), .i_req_valid(valid_a), .i_req_data(data_a),
    .o_req_ready(ready_a), .i_bit_tx(bit_a), .o_start_tx(start_a), .o_tx_frame(tx_frame_a),
    .o_grant_id(grant_a), .o_busy(busy_a), .o_err_timeout(err_a));

  tx_uart_arbiter #(.N_REQ(4), .ID_BITS(2), .GAP_CLOCKS(5), .TIMEOUT_CLOCKS(16)) dut_b (
    .clk(clk), .i_reset_n(rst_n), .i_req_valid(valid_b), .i_req_data(data_b),
    .o_req_ready(ready_b), .i_bit_tx(bit_b), .o_start_tx(start_b), .o_tx_frame(tx_frame_b),
    .o_grant_id(grant_b), .o_busy(busy_b), .o_err_timeout(err_b));

  // Transmitter model A: 10 bits of 4 clocks each, ignores starts while tied idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_a <= 4'hF; baud_a <= 0;
    end else if (start_a && !tie_a) begin
      bit_a <= 4'h0; baud_a <= 0;
    end else if (bit_a != 4'hF) begin
      if (baud_a == 3) begin
        baud_a <= 0;
        bit_a  <= (bit_a == 4'd9) ? 4'hF : bit_a + 4'd1;
      end else begin
        baud_a <= baud_a + 1;
      end
    end
  end

  // Transmitter model B.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_b <= 4'hF; baud_b <= 0;
    end else if (start_b) begin
      bit_b <= 4'h0; baud_b <= 0;
    end else if (bit_b != 4'hF) begin
      if (baud_b == 3) begin
        baud_b <= 0;
        bit_b  <= (bit_b == 4'd9) ? 4'hF : bit_b + 4'd1;
      end else begin
        baud_b <= baud_b + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame on instance A, starting in an IDLE cycle with valid set,
  // and returns in the first IDLE cycle after the transmitter goes idle.
  task automatic do_frame(input string tag, input int exp_id, input logic [7:0] exp_byte);
    bit done;
    chk({tag, "_ready"}, 32'(ready_a), 32'd1 << exp_id);
    @(negedge clk); #1;
    chk({tag, "_start"}, 32'(start_a), 32'd1);
    chk({tag, "_ready_off"}, 32'(ready_a), 32'd0);
    chk({tag, "_grant"}, 32'(grant_a), 32'(exp_id));
    chk({tag, "_frame"}, 32'(tx_frame_a), 32'({1'b1, exp_byte, 1'b0}));
    @(negedge clk); #1;
    chk({tag, "_start_once"}, 32'(start_a), 32'd0);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); #1;
      if (bit_a == 4'hF) done = 1'b1;
    end
    chk({tag, "_txdone"}, 32'(done), 32'd1);
    chk({tag, "_frame_hold"}, 32'(tx_frame_a), 32'({1'b1, exp_byte, 1'b0}));
    chk({tag, "_busy_hold"}, 32'(busy_a), 32'd1);
    @(negedge clk); #1;
    chk({tag, "_idle"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    int  n, nb, first, pulses;
    bit  done;

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_frame", 32'(tx_frame_a), 32'h3FF);
    chk("rst_grant", 32'(grant_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_start", 32'(start_a), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);

    // Single request from requester 1.
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    data_a = 32'h0000A500; valid_a = 4'b0010; #1;
    do_frame("single", 1, 8'hA5);
    valid_a = 4'b0000;
    chk("single_frame", 32'(tx_frame_a), 32'h34A);
    chk("single_persist", 32'(grant_a), 32'd1);

    // Round robin from a freshly reset pointer.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    data_a = 32'h13121110; valid_a = 4'b1111; #1;
    for (int f = 0; f < 5; f++) begin
      do_frame($sformatf("rr%0d", f), f % 4, 8'h10 + 8'(f % 4));
    end
    valid_a = 4'b0000;

    // Pointer wrap: pointer sits at 1, requesters 3 and 0 valid.
    valid_a = 4'b1001; #1;
    for (int f = 0; f < 4; f++) begin
      do_frame($sformatf("wrap%0d", f), (f % 2 == 0) ? 3 : 0, (f % 2 == 0) ? 8'h13 : 8'h10);
    end
    valid_a = 4'b0000;

    // Gap clocks on instance B.
    @(negedge clk); valid_b = 4'b0001; #1;
    chk("gap_ready1", 32'(ready_b), 32'd1);
    @(negedge clk); #1;
    chk("gap_start", 32'(start_b), 32'd1);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); #1;
      if (bit_b == 4'hF) done = 1'b1;
    end
    chk("gap_txdone", 32'(done), 32'd1);
    n = 0; nb = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); #1;
      if (ready_b != 4'b0000) done = 1'b1;
      else begin
        n++;
        if (!busy_b) nb++;
      end
    end
    chk("gap_cycles", 32'(n), 32'd5);
    chk("gap_busy", 32'(nb), 32'd0);
    chk("gap_ready2", 32'(ready_b), 32'd1);
    @(negedge clk); valid_b = 4'b0000;

    // Timeout: transmitter never leaves idle.
    tie_a = 1'b1; valid_a = 4'b0100; #1;
    chk("to_ready", 32'(ready_a), 32'b0100);
    @(negedge clk); #1;
    chk("to_start", 32'(start_a), 32'd1);
    valid_a = 4'b0000;
    first = -1; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (err_a) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    chk("to_delay", 32'(first), 32'd16);
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_idle", 32'(busy_a), 32'd0);
    tie_a = 1'b0;
    @(negedge clk); valid_a = 4'b1000; #1;
    do_frame("after_to", 3, 8'h13);
    valid_a = 4'b0000;

    // Reset in the middle of a frame.
    @(negedge clk); valid_a = 4'b0100; #1;
    chk("mid_ready", 32'(ready_a), 32'b0100);
    @(negedge clk); valid_a = 4'b0000;
    repeat (10) @(negedge clk);
    #1;
    chk("mid_busy", 32'(busy_a), 32'd1);
    chk("mid_grant", 32'(grant_a), 32'd2);
    valid_a = 4'b0101;
    rst_n = 1'b0; #1;
    chk("mid_rst_frame", 32'(tx_frame_a), 32'h3FF);
    chk("mid_rst_grant", 32'(grant_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_start", 32'(start_a), 32'd0);
    chk("mid_rst_ready", 32'(ready_a), 32'd0);
    chk("mid_rst_err", 32'(err_a), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    do_frame("post_rst", 0, 8'h10);
    valid_a = 4'b0000;

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish (observed running, expected done)");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_uart_arbiter.md
Name: tx_uart_arbiter

Overview:
Round-robin controller that shares one UART transmitter among N_REQ byte requesters. It accepts one byte per frame over a valid/ready handshake and builds the 10-bit line frame: start bit, 8 data bits LSB first, stop bit. It pulses the transmitter's start strobe, holds the frame stable for the whole transmission, and tracks the transmitter's bit index until the frame completes. It sits between the byte producers and the tx_uart datapath, and drives that block's i_start_tx and i_data.

Parameters:
N_REQ, 4, number of requesters; legal range 2..16.
ID_BITS, 2, width of the grant index; must equal clog2(N_REQ).
GAP_CLOCKS, 0, idle clocks inserted after each frame completes; 0 = back-to-back frames.
TIMEOUT_CLOCKS, 16, clocks allowed for the transmitter to leave idle after a start pulse.

Ports:
clk  input  1  system clock, rising edge.
i_reset_n  input  1  asynchronous, active-low reset.
i_req_valid  input  N_REQ  per-requester byte valid.
i_req_data  input  8*N_REQ  requester k byte at bits [8k+7:8k].
o_req_ready  output  N_REQ  one-hot accept; transfer when valid&ready at clk edge.
i_bit_tx  input  4  transmitter bit index; 15 = idle, 0..9 = bit in flight.
o_start_tx  output  1  one-cycle start strobe to the transmitter.
o_tx_frame  output  10  frame to the transmitter: bit0 = 0 (start), bits8:1 = data, bit9 = 1 (stop).
o_grant_id  output  ID_BITS  index of the requester whose frame is current.
o_busy  output  1  high whenever state != IDLE.
o_err_timeout  output  1  one-cycle pulse when a start is not acknowledged.

Behaviour:
- Reset (async, i_reset_n=0): state=IDLE; rr_ptr=0; o_start_tx=0; o_req_ready=0; o_tx_frame=10'h3FF; o_grant_id=0; o_busy=0; o_err_timeout=0; gap and timeout counters=0. Asserting reset mid-frame abandons the frame. The transmitter is reset separately.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE, any i_req_valid set:
  - o_req_ready is combinational: one-hot on the first valid index k found scanning from rr_ptr upward with wrap.
  - At the clk edge: latch o_tx_frame={1'b1,data_k,1'b0}; o_grant_id=k; rr_ptr=(k+1) mod N_REQ; go to START.
  - o_req_ready is 0 in every other state, so at most one accept occurs per frame.
- Requester obligations: hold valid and data stable until ready. A valid dropped before ready is simply not serviced.
- START: o_start_tx=1 for exactly this one cycle (Moore, decoded from state); load timeout counter=TIMEOUT_CLOCKS-1; go to WAIT_BUSY.
- WAIT_BUSY:
  - i_bit_tx!=15: go to WAIT_DONE.
  - Otherwise, if the counter is 0: pulse o_err_timeout for 1 cycle, drop the frame, go to IDLE.
  - Otherwise decrement the counter.
- WAIT_DONE: hold o_tx_frame. When i_bit_tx==15: if GAP_CLOCKS==0 go to IDLE, else load gap counter=GAP_CLOCKS-1 and go to GAP.
- GAP: decrement the counter; when it is 0, go to IDLE.
- o_tx_frame and o_grant_id change only on accept. They persist after the frame ends.
- Back-to-back, GAP_CLOCKS=0: the next accept can occur in the first IDLE cycle after i_bit_tx returns to 15.
- Requester valid only for its own index: the arbiter grants it on every frame. Fairness guarantee: with all N_REQ valid, each is granted once per N_REQ frames.
- Timeout counter width: clog2(TIMEOUT_CLOCKS)+1. Gap counter width: clog2(GAP_CLOCKS+1)+1. Neither counter may wrap; both saturate at 0.

Test Plan:
- Single request: requester 1 sends data 8'hA5 against a tx_uart model with CLOCKS_PER_BAUD=4 -> ready[1] high one cycle; o_tx_frame=10'h34A; o_start_tx one pulse; o_grant_id=1; o_busy falls after i_bit_tx returns to 15.
- Round robin: all 4 valid continuously, bytes 8'h10..8'h13 -> grants in order 0,1,2,3,0. Each frame's o_tx_frame bits8:1 match the granted byte.
- Pointer wrap: only requesters 3 and 0 valid, rr_ptr=3 -> grants 3,0,3,0. Never two grants to the same index in a row.
- Gap: GAP_CLOCKS=5, two back-to-back requests -> exactly 5 GAP cycles between i_bit_tx==15 and the second ready pulse.
- Timeout: i_bit_tx tied to 15 -> o_err_timeout pulses exactly TIMEOUT_CLOCKS=16 cycles after the START cycle. State returns to IDLE, and the next request is accepted normally.
- Reset mid-frame: drop i_reset_n while in WAIT_DONE -> all outputs take reset values immediately; o_tx_frame=10'h3FF; after release, a new request is granted starting from index 0.
